// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader writing 12-bit words to program memory.
// Optional trailing XOR checksum byte enabled by macro PROG_LOADER_CHECKSUM_EN.
module prog_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        LE,
  output logic [7:0]  LA,
  output logic [11:0] LI,
  output logic        load_done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_LO,
    S_HI,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_addr;
  logic [7:0]  r_lo;
  logic [7:0]  r_acc;

  state_t      w_state;
  logic [7:0]  w_cnt;
  logic [7:0]  w_addr;
  logic [7:0]  w_lo;
  logic [7:0]  w_acc;
  logic        w_le;
  logic [7:0]  w_la;
  logic [11:0] w_li;
  logic        w_done;
  logic        w_err;
  logic        w_xfer;
  logic        w_active;

  // in_ready mirrors the registered state, so a transfer is valid+ready.
  assign w_xfer = in_valid && in_ready;

  // Next-state and next-output logic.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_lo    = r_lo;
    w_acc   = r_acc;
    w_le    = 1'b0;
    w_la    = LA;
    w_li    = LI;
    w_done  = load_done;
    w_err   = err;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state = S_COUNT;
          w_done  = 1'b0;
          w_err   = 1'b0;
          w_addr  = 8'd0;
          w_acc   = 8'd0;
        end
      end
      S_COUNT: begin
        if (w_xfer) begin
          w_acc = r_acc ^ in_data;
          w_cnt = in_data;
          if (in_data == 8'd0) begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end else begin
            w_state = S_LO;
          end
        end
      end
      S_LO: begin
        if (w_xfer) begin
          w_acc   = r_acc ^ in_data;
          w_lo    = in_data;
          w_state = S_HI;
        end
      end
      S_HI: begin
        if (w_xfer) begin
          w_acc  = r_acc ^ in_data;
          w_le   = 1'b1;
          w_la   = r_addr;
          w_li   = {in_data[3:0], r_lo};
          w_addr = r_addr + 8'd1;
          w_cnt  = r_cnt - 8'd1;
          if (r_cnt != 8'd1) begin
            w_state = S_LO;
          end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
            w_state = S_CSUM;
`else
            w_state = S_DONE;
            w_done  = 1'b1;
`endif
          end
        end
      end
      S_CSUM: begin
        if (w_xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (in_data == r_acc) begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end else begin
            w_state = S_ERROR;
            w_err   = 1'b1;
          end
`else
          w_state = S_DONE;
          w_done  = 1'b1;
`endif
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign w_active = (w_state == S_COUNT) || (w_state == S_LO) ||
                    (w_state == S_HI) || (w_state == S_CSUM);

  // State, datapath and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_addr    <= 8'd0;
      r_lo      <= 8'd0;
      r_acc     <= 8'd0;
      in_ready  <= 1'b0;
      LE        <= 1'b0;
      LA        <= 8'd0;
      LI        <= 12'd0;
      load_done <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_addr    <= w_addr;
      r_lo      <= w_lo;
      r_acc     <= w_acc;
      in_ready  <= w_active;
      LE        <= w_le;
      LA        <= w_la;
      LI        <= w_li;
      load_done <= w_done;
      busy      <= w_active;
      err       <= w_err;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed stimulus, LE writes checked by a queue scoreboard.
// Build with PROG_LOADER_CHECKSUM_EN defined to exercise the checksum paths.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        LE;
  logic [7:0]  LA;
  logic [11:0] LI;
  logic        load_done;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;
  logic [7:0] acc = 8'd0;
  logic [19:0] exp_q[$];

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .LE(LE), .LA(LA), .LI(LI),
    .load_done(load_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every LE strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && LE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL le_unexpected: got LA=%0h LI=%0h expected no write",
                 LA, LI);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({LA, LI} !== e) begin
          errors++;
          $display("FAIL le_write: got LA=%0h LI=%0h expected LA=%0h LI=%0h",
                   LA, LI, e[19:12], e[11:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    acc = acc ^ b;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic begin_load();
    pulse_start();
    acc = 8'd0;
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [11:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic finish_load(input logic good);
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = good ? acc : (acc ^ 8'h01);
    send(c);
`else
    if (!good) $display("note: checksum mismatch case needs checksum build");
`endif
  endtask

  task automatic stall(input int k);
    repeat (k) begin
      @(negedge clk);
      chk("busy_stall", 32'(busy), 32'd1);
    end
  endtask

  task automatic chk_reset_vals();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_LE", 32'(LE), 32'd0);
    chk("rst_LA", 32'(LA), 32'd0);
    chk("rst_LI", 32'(LI), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  task automatic chk_done();
    @(negedge clk);
    chk("done_load_done", 32'(load_done), 32'd1);
    chk("done_err", 32'(err), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_LE", 32'(LE), 32'd0);

    // Continuous stream N=2.
    begin_load();
    @(negedge clk);
    chk("count_busy", 32'(busy), 32'd1);
    chk("count_in_ready", 32'(in_ready), 32'd1);
    expect_wr(8'h00, 12'h134);
    expect_wr(8'h01, 12'hF56);
    send(8'h02);
    send(8'h34);
    send(8'h01);
    send(8'h56);
    send(8'h0F);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h6E);
`endif
    chk_done();

`ifdef PROG_LOADER_CHECKSUM_EN
    // Same stream, bad checksum.
    begin_load();
    expect_wr(8'h00, 12'h134);
    expect_wr(8'h01, 12'hF56);
    send(8'h02);
    send(8'h34);
    send(8'h01);
    send(8'h56);
    send(8'h0F);
    send(8'h6F);
    @(negedge clk);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_load_done", 32'(load_done), 32'd0);
    chk("bad_in_ready", 32'(in_ready), 32'd0);
`endif

    // N=0: straight to DONE, no writes.
    begin_load();
    send(8'h00);
    chk_done();

    // N=3 with 4-cycle stalls between every byte.
    begin_load();
    expect_wr(8'h00, 12'h211);
    expect_wr(8'h01, 12'h322);
    expect_wr(8'h02, 12'h433);
    send(8'h03); stall(4);
    send(8'h11); stall(4);
    send(8'hA2); stall(4);
    send(8'h22); stall(4);
    send(8'hB3); stall(4);
    send(8'h33); stall(4);
    send(8'hC4);
`ifdef PROG_LOADER_CHECKSUM_EN
    stall(4);
`endif
    finish_load(1'b1);
    chk_done();

    // Reset in the middle of an N=4 load.
    begin_load();
    expect_wr(8'h00, 12'h110);
    send(8'h04);
    send(8'h10);
    send(8'h01);
    send(8'h20);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_LA", 32'(LA), 32'd0);
    chk("mid_rst_LI", 32'(LI), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_load_done", 32'(load_done), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_le", 32'(LE), 32'd0);
    end
    in_valid = 1'b0;
    begin_load();
    expect_wr(8'h00, 12'h755);
    send(8'h01);
    send(8'h55);
    send(8'h07);
    finish_load(1'b1);
    chk_done();

    // Start pulses while busy must be ignored.
    begin_load();
    expect_wr(8'h00, 12'h140);
    expect_wr(8'h01, 12'h250);
    send(8'h02);
    pulse_start();
    @(negedge clk);
    chk("busy_start_busy", 32'(busy), 32'd1);
    send(8'h40);
    send(8'h01);
    pulse_start();
    send(8'h50);
    send(8'h02);
    finish_load(1'b1);
    chk_done();

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-low (rst==0 at posedge clk resets the block).
REQ-003 SHALL have port start  input  1  one-cycle request to begin a program load; sampled only in IDLE, DONE, ERROR.
REQ-004 SHALL have port in_valid  input  1  byte-stream source has a byte on in_data.
REQ-005 SHALL have port in_data  input  8  byte-stream data.
REQ-006 SHALL have port in_ready  output  1  loader accepts a byte; transfer occurs when in_valid && in_ready at posedge.
REQ-007 SHALL have port LE  output  1  program-memory load-enable write strobe, one cycle per instruction.
REQ-008 SHALL have port LA  output  8  program-memory load address, valid while LE==1.
REQ-009 SHALL have port LI  output  12  program-memory load instruction, valid while LE==1.
REQ-010 SHALL have port load_done  output  1  level, program fully loaded without error.
REQ-011 SHALL have port busy  output  1  level, load in progress.
REQ-012 SHALL have port err  output  1  level, load aborted on checksum mismatch.

Function
REQ-013 SHALL implement states IDLE, COUNT, LO, HI, CSUM, DONE, ERROR; all outputs registered.
REQ-014 SHALL move IDLE/DONE/ERROR -> COUNT on start==1, clearing load_done, err, write address counter and checksum accumulator.
REQ-015 SHALL in COUNT accept one byte as instruction count N (8-bit); N==0 -> DONE directly, no LE pulse; else -> LO.
REQ-016 SHALL in LO accept byte as LI[7:0] candidate, -> HI.
REQ-017 SHALL in HI accept byte; in_data[3:0] becomes LI[11:8], in_data[7:4] ignored; -> LO if instructions remaining, else -> CSUM (macro defined) or DONE (macro undefined).
REQ-018 SHALL assert LE for exactly the one cycle after each HI-byte transfer, with LA = write counter and LI = assembled word; counter increments after the write.
REQ-019 SHALL write addresses 0..N-1 in order; LA never wraps since N<=255.
REQ-020 SHALL drive in_ready=1 in COUNT, LO, HI, CSUM and 0 in IDLE, DONE, ERROR; no extra wait cycles, so back-to-back bytes accept at one per cycle.
REQ-021 SHALL hold state and data unchanged while in_valid==0 (stalls at any byte boundary are legal).
REQ-022 SHALL drive busy=1 in COUNT, LO, HI, CSUM; 0 otherwise.
REQ-023 SHALL in DONE hold load_done=1 until start or reset; start in DONE begins a new load.
REQ-024 SHALL ignore start while busy==1.
REQ-025 SHALL give reset priority over start, in_valid and any pending LE (reset mid-load: no further LE, state IDLE next cycle).

Reset
REQ-026 SHALL on rst==0 set state IDLE, in_ready=0, LE=0, LA=0, LI=0, load_done=0, busy=0, err=0, counters and accumulator 0.
REQ-027 SHALL produce no LE pulse in the cycle following reset release.

Configuration
REQ-028 SHALL support macro PROG_LOADER_CHECKSUM_EN.
REQ-029 With PROG_LOADER_CHECKSUM_EN defined: accumulator = XOR of all bytes accepted from COUNT through the last HI; CSUM accepts one byte; match -> DONE, mismatch -> ERROR (err=1, load_done=0); all N LE writes already issued remain.
REQ-030 With PROG_LOADER_CHECKSUM_EN undefined: CSUM and ERROR unreachable, no checksum byte consumed, err tied 0.

Verification
REQ-031 SHALL cover: reset, start, bytes 02,34,01,56,0F streamed continuously (checksum macro on, 02^34^01^56^0F=6E -> send 6E) -> LE pulses LA=00 LI=134, LA=01 LI=F56, then load_done=1, err=0.
REQ-032 SHALL cover: same stream with checksum byte 6F (macro on) -> both LE writes occur, then err=1, load_done=0, in_ready=0.
REQ-033 SHALL cover: start, count byte 00 -> no LE, load_done=1 one cycle after transfer (no checksum byte consumed).
REQ-034 SHALL cover: N=3 with in_valid deasserted 4 cycles between every byte -> identical LA/LI sequence 00,01,02 as continuous stream, busy high throughout.
REQ-035 SHALL cover: rst driven 0 for one cycle after second LO byte of N=4 load -> no further LE, all outputs at reset values, subsequent start loads from LA=00.
REQ-036 SHALL cover: start pulsed while busy -> ignored, load completes with original N (macro off build: load_done=1 right after final HI byte's LE).
